// File: rtl/ascon_perm_ctrl.sv
// Ascon permutation controller: constant addition and linear layer in place, S-box layer
// streamed through an external bit-sliced S-box `width` bits per cycle.
module ascon_perm_ctrl #(
  parameter int width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [3:0]       rounds_i,
  input  logic [319:0]     state_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [319:0]     state_o,
  output logic [width-1:0] sb_x0_o,
  output logic [width-1:0] sb_x1_o,
  output logic [width-1:0] sb_x2_o,
  output logic [width-1:0] sb_x3_o,
  output logic [width-1:0] sb_x4_o,
  input  logic [width-1:0] sb_x0_i,
  input  logic [width-1:0] sb_x1_i,
  input  logic [width-1:0] sb_x2_i,
  input  logic [width-1:0] sb_x3_i,
  input  logic [width-1:0] sb_x4_i
);

  localparam int N = 64 / width;
  localparam logic [6:0] SUB_LAST = 7'(N - 1);

  typedef enum logic [2:0] {IDLE, CONST, SUB, LIN, DONE} state_t;

  state_t           st, st_nxt;
  logic [63:0]      x      [5];
  logic [width-1:0] sb_ret [5];
  logic [6:0]       sub_cnt;
  logic [3:0]       rnd;

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [63:0] lin(input int k, input logic [63:0] v);
    logic [63:0] r;
    case (k)
      0:       r = v ^ ror(v, 19) ^ ror(v, 28);
      1:       r = v ^ ror(v, 61) ^ ror(v, 39);
      2:       r = v ^ ror(v, 1)  ^ ror(v, 6);
      3:       r = v ^ ror(v, 10) ^ ror(v, 17);
      default: r = v ^ ror(v, 7)  ^ ror(v, 41);
    endcase
    return r;
  endfunction

  // Out-of-range round counts run the full 12 rounds.
  function automatic logic [3:0] first_rnd(input logic [3:0] r);
    if (r == 4'd0 || r > 4'd12) return 4'd0;
    return 4'd12 - r;
  endfunction

  function automatic logic [7:0] rc(input logic [3:0] i);
    return {4'd15 - i, i};
  endfunction

  // After N shifts every word is back in its original bit alignment.
  function automatic logic [63:0] sub_shift(input logic [63:0] w, input logic [width-1:0] s);
    logic [64+width-1:0] cat;
    cat = {s, w};
    return cat[64+width-1:width];
  endfunction

  assign sb_ret[0] = sb_x0_i;
  assign sb_ret[1] = sb_x1_i;
  assign sb_ret[2] = sb_x2_i;
  assign sb_ret[3] = sb_x3_i;
  assign sb_ret[4] = sb_x4_i;

  assign sb_x0_o = x[0][width-1:0];
  assign sb_x1_o = x[1][width-1:0];
  assign sb_x2_o = x[2][width-1:0];
  assign sb_x3_o = x[3][width-1:0];
  assign sb_x4_o = x[4][width-1:0];

  assign state_o = {x[0], x[1], x[2], x[3], x[4]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) st <= IDLE;
    else         st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    busy_o = 1'b0;
    done_o = 1'b0;
    case (st)
      IDLE:  if (start_i) st_nxt = CONST;
      CONST: begin
        busy_o = 1'b1;
        st_nxt = SUB;
      end
      SUB: begin
        busy_o = 1'b1;
        if (sub_cnt == SUB_LAST) st_nxt = LIN;
      end
      LIN: begin
        busy_o = 1'b1;
        st_nxt = (rnd == 4'd11) ? DONE : CONST;
      end
      DONE: begin
        done_o = 1'b1;
        st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < 5; k++) x[k] <= '0;
      sub_cnt <= '0;
      rnd     <= '0;
    end else begin
      case (st)
        IDLE: if (start_i) begin
          for (int k = 0; k < 5; k++) x[k] <= state_i[64*(4-k) +: 64];
          rnd     <= first_rnd(rounds_i);
          sub_cnt <= '0;
        end
        CONST: x[2] <= x[2] ^ {56'd0, rc(rnd)};
        SUB: begin
          for (int k = 0; k < 5; k++) x[k] <= sub_shift(x[k], sb_ret[k]);
          sub_cnt <= (sub_cnt == SUB_LAST) ? 7'd0 : sub_cnt + 7'd1;
        end
        LIN: begin
          for (int k = 0; k < 5; k++) x[k] <= lin(k, x[k]);
          rnd <= rnd + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Bench for ascon_perm_ctrl: widths 1, 8 and 64 run side by side against a word-level
// Ascon permutation model, with an ideal external bit-sliced S-box per instance.
module tb_ascon_perm_ctrl;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   rounds = '0;
  logic [319:0] st_in = '0;

  logic [2:0]   busy_v, done_v;
  logic [319:0] so_v [3];

  logic [0:0]   so1 [5], si1 [5];
  logic [7:0]   so8 [5], si8 [5];
  logic [63:0]  so64[5], si64[5];
  logic [319:0] r1, r8, r64;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [319:0] sbox(input logic [319:0] s);
    logic [63:0] a0, a1, a2, a3, a4, t0, t1, t2, t3, t4;
    {a0, a1, a2, a3, a4} = s;
    a0 ^= a4; a4 ^= a3; a2 ^= a1;
    t0 = ~a0 & a1; t1 = ~a1 & a2; t2 = ~a2 & a3; t3 = ~a3 & a4; t4 = ~a4 & a0;
    a0 ^= t1; a1 ^= t2; a2 ^= t3; a3 ^= t4; a4 ^= t0;
    a1 ^= a0; a0 ^= a4; a3 ^= a2; a2 = ~a2;
    return {a0, a1, a2, a3, a4};
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic int eff(input int r);
    return (r == 0 || r > 12) ? 12 : r;
  endfunction

  function automatic int nsub(input int j);
    return (j == 0) ? 64 : (j == 1) ? 8 : 1;
  endfunction

  function automatic logic [319:0] perm(input logic [319:0] s, input int r);
    logic [319:0] t;
    logic [63:0] a0, a1, a2, a3, a4;
    t = s;
    for (int i = 12 - eff(r); i < 12; i++) begin
      t[135:128] ^= 8'(((15 - i) << 4) | i);
      t = sbox(t);
      {a0, a1, a2, a3, a4} = t;
      t = {a0 ^ ror(a0, 19) ^ ror(a0, 28), a1 ^ ror(a1, 61) ^ ror(a1, 39),
           a2 ^ ror(a2, 1) ^ ror(a2, 6), a3 ^ ror(a3, 10) ^ ror(a3, 17),
           a4 ^ ror(a4, 7) ^ ror(a4, 41)};
    end
    return t;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    v = '0;
    for (int i = 0; i < 10; i++) v = {v[287:0], 32'($urandom)};
    return v;
  endfunction

  // External S-box for each instance; bit-slicing lets a zero-extended slice be used.
  always_comb begin
    r1 = sbox({64'(so1[0]), 64'(so1[1]), 64'(so1[2]), 64'(so1[3]), 64'(so1[4])});
    for (int k = 0; k < 5; k++) si1[k] = r1[64*(4-k) +: 1];
  end
  always_comb begin
    r8 = sbox({64'(so8[0]), 64'(so8[1]), 64'(so8[2]), 64'(so8[3]), 64'(so8[4])});
    for (int k = 0; k < 5; k++) si8[k] = r8[64*(4-k) +: 8];
  end
  always_comb begin
    r64 = sbox({so64[0], so64[1], so64[2], so64[3], so64[4]});
    for (int k = 0; k < 5; k++) si64[k] = r64[64*(4-k) +: 64];
  end

  ascon_perm_ctrl #(.width(1)) u_w1 (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .rounds_i(rounds), .state_i(st_in),
    .busy_o(busy_v[0]), .done_o(done_v[0]), .state_o(so_v[0]),
    .sb_x0_o(so1[0]), .sb_x1_o(so1[1]), .sb_x2_o(so1[2]), .sb_x3_o(so1[3]), .sb_x4_o(so1[4]),
    .sb_x0_i(si1[0]), .sb_x1_i(si1[1]), .sb_x2_i(si1[2]), .sb_x3_i(si1[3]), .sb_x4_i(si1[4])
  );

  ascon_perm_ctrl #(.width(8)) u_w8 (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .rounds_i(rounds), .state_i(st_in),
    .busy_o(busy_v[1]), .done_o(done_v[1]), .state_o(so_v[1]),
    .sb_x0_o(so8[0]), .sb_x1_o(so8[1]), .sb_x2_o(so8[2]), .sb_x3_o(so8[3]), .sb_x4_o(so8[4]),
    .sb_x0_i(si8[0]), .sb_x1_i(si8[1]), .sb_x2_i(si8[2]), .sb_x3_i(si8[3]), .sb_x4_i(si8[4])
  );

  ascon_perm_ctrl #(.width(64)) u_w64 (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .rounds_i(rounds), .state_i(st_in),
    .busy_o(busy_v[2]), .done_o(done_v[2]), .state_o(so_v[2]),
    .sb_x0_o(so64[0]), .sb_x1_o(so64[1]), .sb_x2_o(so64[2]), .sb_x3_o(so64[3]),
    .sb_x4_o(so64[4]),
    .sb_x0_i(si64[0]), .sb_x1_i(si64[1]), .sb_x2_i(si64[2]), .sb_x3_i(si64[3]),
    .sb_x4_i(si64[4])
  );

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 320'(busy_v), '0);
    chk({tag, "_done"}, 320'(done_v), '0);
    for (int j = 0; j < 3; j++) chk($sformatf("%s_state_w%0d", tag, j), so_v[j], '0);
    chk({tag, "_sb1"}, 320'({so1[0], so1[1], so1[2], so1[3], so1[4]}), '0);
    chk({tag, "_sb8"}, 320'({so8[0], so8[1], so8[2], so8[3], so8[4]}), '0);
    chk({tag, "_sb64"}, {so64[0], so64[1], so64[2], so64[3], so64[4]}, '0);
  endtask

  // One permutation on all three instances; inputs are scrambled right after acceptance.
  task automatic run_perm(input logic [319:0] s, input logic [3:0] r, input bit chk_const);
    int lat[3], pulses[3], lim;
    logic [319:0] exp;
    exp = perm(s, int'(r));
    lim = eff(int'(r)) * 66 + 3;
    st_in = s; rounds = r; start = 1'b1;
    step();
    start = 1'b0; st_in = rand320(); rounds = 4'($urandom);
    for (int j = 0; j < 3; j++) begin
      lat[j] = -1;
      pulses[j] = 0;
    end
    for (int k = 1; k <= lim; k++) begin
      step();
      if (k == 1) begin
        chk("busy_after_start", 320'(busy_v), 320'(3'b111));
        if (chk_const)
          for (int j = 0; j < 3; j++) chk($sformatf("const_x2_w%0d", j), 320'(so_v[j][191:128]), 320'h4B);
      end
      for (int j = 0; j < 3; j++) if (done_v[j]) begin
        pulses[j]++;
        if (lat[j] < 0) begin
          lat[j] = k;
          chk($sformatf("result_w%0d_r%0d", j, r), so_v[j], exp);
          chk($sformatf("busy_in_done_w%0d", j), 320'(busy_v[j]), '0);
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("latency_w%0d_r%0d", j, r), 320'(lat[j]), 320'(eff(int'(r)) * (nsub(j) + 2)));
      chk($sformatf("pulses_w%0d", j), 320'(pulses[j]), 320'(1));
      chk($sformatf("hold_w%0d", j), so_v[j], exp);
    end
  endtask

  task automatic held_start();
    localparam int P = 300;
    logic [319:0] hist [P+1];
    int cnt[3], L, per, a;
    for (int j = 0; j < 3; j++) cnt[j] = 0;
    hist[0] = rand320();
    st_in = hist[0]; rounds = 4'd2; start = 1'b1;
    step();
    for (int k = 1; k <= P; k++) begin
      hist[k] = rand320();
      st_in = hist[k];
      step();
      for (int j = 0; j < 3; j++) if (done_v[j]) begin
        cnt[j]++;
        L = 2 * (nsub(j) + 2);
        per = L + 2;
        a = k - L;
        chk($sformatf("held_sched_w%0d", j), 320'(a >= 0 && (a % per) == 0), 320'(1));
        if (a >= 0) chk($sformatf("held_result_w%0d", j), so_v[j], perm(hist[a], 2));
      end
    end
    for (int j = 0; j < 3; j++) begin
      L = 2 * (nsub(j) + 2);
      chk($sformatf("held_count_w%0d", j), 320'(cnt[j]), 320'((P - L) / (L + 2) + 1));
    end
    start = 1'b0;
    repeat (140) step();
    chk("held_drained", 320'(busy_v), '0);
  endtask

  initial begin
    logic [319:0] s;
    #2 rst_ni = 1'b0;
    #1 chk_all_zero("reset");
    step();
    rst_ni = 1'b1;
    step();
    chk("idle_after_reset", 320'({busy_v, done_v}), '0);

    run_perm('0, 4'd12, 1'b0);
    run_perm('0, 4'd1, 1'b1);
    run_perm(rand320(), 4'd6, 1'b0);
    s = rand320();
    run_perm(s, 4'd0, 1'b0);
    run_perm(s, 4'd15, 1'b0);
    run_perm(s, 4'd12, 1'b0);
    for (int t = 0; t < 3; t++) run_perm(rand320(), 4'($urandom_range(1, 11)), 1'b0);

    held_start();

    // Asynchronous reset in the SUB phase of round 3 on the width-1 instance.
    st_in = rand320(); rounds = 4'd12; start = 1'b1;
    step();
    start = 1'b0;
    repeat (140) step();
    chk("busy_before_reset", 320'(busy_v[0]), 320'(1));
    #2 rst_ni = 1'b0;
    #1 chk_all_zero("midrun_reset");
    step();
    chk_all_zero("reset_held");
    rst_ni = 1'b1;
    step();
    chk("idle_after_midrun_reset", 320'(busy_v), '0);
    run_perm(rand320(), 4'd3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
